// File: rtl/bram_write_arbiter.sv
// Frame-buffer BRAM port A arbiter: UART pixel writes take priority,
// a fill engine sweeps every address with one colour in the remaining cycles.
module bram_write_arbiter #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH      = 196608
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  px_valid,
    input  logic [ADDR_WIDTH-1:0] px_addr,
    input  logic [DATA_WIDTH-1:0] px_data,
    input  logic                  fill_start,
    input  logic [DATA_WIDTH-1:0] fill_color,
    output logic                  en,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           stall_count
);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] fill_cnt;
    logic [DATA_WIDTH-1:0] color;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fill_cnt    <= '0;
            color       <= '0;
            en          <= 1'b0;
            we          <= 1'b0;
            addr        <= '0;
            din         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            stall_count <= '0;
        end else begin
            done <= 1'b0;

            // Port A mux: UART first, then fill; addr/din hold when idle.
            if (px_valid) begin
                en   <= 1'b1;
                we   <= 1'b1;
                addr <= px_addr;
                din  <= px_data;
            end else if (state == FILL) begin
                en   <= 1'b1;
                we   <= 1'b1;
                addr <= fill_cnt;
                din  <= color;
            end else begin
                en <= 1'b0;
                we <= 1'b0;
            end

            case (state)
                IDLE: begin
                    busy <= fill_start;
                    if (fill_start) begin
                        state       <= FILL;
                        color       <= fill_color;
                        fill_cnt    <= '0;
                        stall_count <= '0;
                    end
                end
                FILL: begin
                    // busy stays high into the done cycle; IDLE drops it one cycle later.
                    busy <= 1'b1;
                    if (px_valid) begin
                        if (stall_count != '1)
                            stall_count <= stall_count + 16'd1;
                    end else if (fill_cnt == LAST_ADDR) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_write_arbiter.sv
// Directed bench for bram_write_arbiter with DEPTH=16: vector table for reset
// and UART passthrough, cycle-indexed sequences for fill, contention and abort.
module tb_bram_write_arbiter;

    localparam int AW = 18;
    localparam int DW = 24;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          px_valid;
    logic [AW-1:0] px_addr;
    logic [DW-1:0] px_data;
    logic          fill_start;
    logic [DW-1:0] fill_color;
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          busy;
    logic          done;
    logic [15:0]   stall_count;

    int compared = 0;
    int mismatched = 0;

    bram_write_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .px_valid   (px_valid),
        .px_addr    (px_addr),
        .px_data    (px_data),
        .fill_start (fill_start),
        .fill_color (fill_color),
        .en         (en),
        .we         (we),
        .addr       (addr),
        .din        (din),
        .busy       (busy),
        .done       (done),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          pv;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic          busy;
        logic          done;
        logic [15:0]   stall;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fill starting in cycle 0; optional 2-cycle UART burst in cycles st, st+1
    // and optional ignored fill_start in cycle rs.
    task automatic run_fill(input logic [DW-1:0] col, input int st, input int rs);
        int stalls;
        int last;
        int fa;
        stalls = (st >= 0) ? 2 : 0;
        last = DEPTH + 1 + stalls;
        fill_start = 1'b1;
        fill_color = col;
        px_valid = 1'b0;
        for (int c = 1; c <= last + 2; c++) begin
            step();
            check($sformatf("busy c%0d", c), 32'(busy), 32'(c <= last));
            check($sformatf("done c%0d", c), 32'(done), 32'(c == last));
            check($sformatf("en c%0d", c), 32'(en), 32'(c >= 2 && c <= last));
            check($sformatf("we c%0d", c), 32'(we), 32'(c >= 2 && c <= last));
            if (c >= 2 && c <= last) begin
                if (st >= 0 && (c == st + 1 || c == st + 2)) begin
                    check($sformatf("uart addr c%0d", c), 32'(addr), 32'd100);
                    check($sformatf("uart din c%0d", c), 32'(din), 32'hFFFFFF);
                end else begin
                    fa = c - 2 - ((st >= 0 && c > st + 2) ? 2 : 0);
                    check($sformatf("fill addr c%0d", c), 32'(addr), 32'(fa));
                    check($sformatf("fill din c%0d", c), 32'(din), 32'(col));
                end
            end
            fill_start = (c == rs);
            fill_color = (c == rs) ? 24'hFFFFFF : col;
            px_valid = (st >= 0 && (c == st || c == st + 1));
            px_addr = 18'd100;
            px_data = 24'hFFFFFF;
        end
        check("stall_count end", 32'(stall_count), 32'(stalls));
        fill_start = 1'b0;
        px_valid = 1'b0;
    endtask

    vec_t vt[7];

    initial begin
        vt[0] = '{1, 1, 18'd9, 24'hAAAAAA, 0, 18'd0, 24'h0, 0, 0, 16'd0};
        vt[1] = '{1, 1, 18'd9, 24'hAAAAAA, 0, 18'd0, 24'h0, 0, 0, 16'd0};
        vt[2] = '{0, 0, 18'd9, 24'hAAAAAA, 0, 18'd0, 24'h0, 0, 0, 16'd0};
        vt[3] = '{0, 1, 18'd5, 24'hA1B2C3, 1, 18'd5, 24'hA1B2C3, 0, 0, 16'd0};
        vt[4] = '{0, 1, 18'd6, 24'h010203, 1, 18'd6, 24'h010203, 0, 0, 16'd0};
        vt[5] = '{0, 0, 18'd0, 24'h0, 0, 18'd6, 24'h010203, 0, 0, 16'd0};
        vt[6] = '{0, 0, 18'd0, 24'h0, 0, 18'd6, 24'h010203, 0, 0, 16'd0};

        rst = 1'b1;
        px_valid = 1'b0;
        px_addr = '0;
        px_data = '0;
        fill_start = 1'b0;
        fill_color = '0;
        #1;

        for (int i = 0; i < 7; i++) begin
            rst = vt[i].rst;
            px_valid = vt[i].pv;
            px_addr = vt[i].pa;
            px_data = vt[i].pd;
            step();
            check($sformatf("v%0d en", i), 32'(en), 32'(vt[i].en));
            check($sformatf("v%0d we", i), 32'(we), 32'(vt[i].en));
            check($sformatf("v%0d addr", i), 32'(addr), 32'(vt[i].addr));
            check($sformatf("v%0d din", i), 32'(din), 32'(vt[i].din));
            check($sformatf("v%0d busy", i), 32'(busy), 32'(vt[i].busy));
            check($sformatf("v%0d done", i), 32'(done), 32'(vt[i].done));
            check($sformatf("v%0d stall", i), 32'(stall_count), 32'(vt[i].stall));
        end
        px_valid = 1'b0;

        // Uncontended, contended, and fill with ignored restart in cycle 8.
        run_fill(24'h00FF00, -1, -1);
        run_fill(24'h123456, 3, -1);
        run_fill(24'hABCDEF, -1, 8);

        // Abort while fill address 7 is on the port.
        fill_start = 1'b1;
        fill_color = 24'h00FF00;
        for (int c = 1; c <= 9; c++) begin
            step();
            fill_start = 1'b0;
        end
        check("abort pre en", 32'(en), 32'd1);
        check("abort pre addr", 32'(addr), 32'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort en", 32'(en), 32'd0);
        check("abort addr", 32'(addr), 32'd0);
        check("abort din", 32'(din), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort stall", 32'(stall_count), 32'd0);
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("post-abort done %0d", c), 32'(done), 32'd0);
            check($sformatf("post-abort en %0d", c), 32'(en), 32'd0);
        end
        run_fill(24'h00FF00, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
